pcie_src_ctrl: RTL and testbench

- Source-side flow controller sitting directly upstream of the PCIe transaction top.
- Takes 6-bit words from a producer via a valid/ready handshake and buffers them in a 4-entry skid FIFO.
- Drives push/data into the main FIFO, honouring the main FIFO's Pausa_MF back-pressure.
- Word format: bit5 = vc_id, bit4 = destination, bits3:0 = payload.

---
 rtl/pcie_src_ctrl.sv | 152 +++++++++++++++
 tb/tb_pcie_src_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_src_ctrl.sv
// pcie_src_ctrl: source-side flow controller upstream of the PCIe transaction top.
// Buffers 6-bit producer words in a small skid FIFO and pushes them one per cycle
// into the main FIFO, stalling on Pausa_MF.
// Optional build macro PCIE_SRC_STATS_EN: when defined, per-VC push counters are
// built; otherwise cnt_vc0/cnt_vc1 are tied to zero.
module pcie_src_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic             in_valid,
  input  logic [5:0]       in_data,
  output logic             in_ready,
  input  logic             Pausa_MF,
  output logic             push,
  output logic [5:0]       data_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] cnt_vc0,
  output logic [CNT_W-1:0] cnt_vc1,
  output logic             busy
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [5:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_occ;
  logic [PTR_W:0]   w_occ_nxt;
  logic             r_push;
  logic [5:0]       r_data_out;
  logic             w_wr;
  logic             w_pop;
  logic             w_flush;
  logic [5:0]       w_head;

  // in_ready is judged on pre-pop occupancy, so a full buffer never bypasses.
  assign in_ready = (r_occ < LP_FULL) && (r_state != ST_INIT);
  assign w_wr     = in_valid & in_ready;
  assign w_flush  = init | (r_state == ST_INIT);
  assign w_pop    = (r_state == ST_SEND) & ~Pausa_MF & (r_occ != '0) & ~init;
  assign w_head   = r_mem[r_rptr];

  // Occupancy after this edge's write and pop.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr, w_pop})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // FSM next state; init overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (init) begin
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:  w_state_nxt = ST_IDLE;
        ST_IDLE:  if (w_occ_nxt != '0) w_state_nxt = ST_SEND;
        ST_SEND: begin
          if (Pausa_MF)               w_state_nxt = ST_PAUSE;
          else if (w_occ_nxt == '0)   w_state_nxt = ST_IDLE;
        end
        ST_PAUSE: begin
          if (w_occ_nxt == '0)        w_state_nxt = ST_IDLE;
          else if (!Pausa_MF)         w_state_nxt = ST_SEND;
        end
        default:  w_state_nxt = ST_INIT;
      endcase
    end
  end

  // State, pointers and occupancy; flushed while initialising.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_INIT;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
    end else if (w_flush) begin
      r_state <= w_state_nxt;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_data;
  end

  // Registered push strobe and word towards the main FIFO.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_push     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_push <= w_pop;
      if (w_pop) r_data_out <= w_head;
    end
  end

`ifdef PCIE_SRC_STATS_EN
  logic [CNT_W-1:0] r_cnt_vc0;
  logic [CNT_W-1:0] r_cnt_vc1;

  // Per-VC push counters, steered by the vc_id bit of the popped word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt_vc0 <= '0;
      r_cnt_vc1 <= '0;
    end else if (w_flush) begin
      r_cnt_vc0 <= '0;
      r_cnt_vc1 <= '0;
    end else if (w_pop) begin
      if (w_head[5]) r_cnt_vc1 <= r_cnt_vc1 + 1'b1;
      else           r_cnt_vc0 <= r_cnt_vc0 + 1'b1;
    end
  end

  assign cnt_vc0 = r_cnt_vc0;
  assign cnt_vc1 = r_cnt_vc1;
`else
  assign cnt_vc0 = '0;
  assign cnt_vc1 = '0;
`endif

  assign push      = r_push;
  assign data_out  = r_data_out;
  assign state_out = r_state;
  assign busy      = (r_occ != '0) | r_push;

endmodule

// File: tb/tb_pcie_src_ctrl.sv
// Self-checking bench for pcie_src_ctrl: scoreboard of accepted words checked
// against every push, plus per-scenario inline checks.
module tb_pcie_src_ctrl;

`ifdef PCIE_SRC_STATS_EN
  localparam int Stats = 1;
`else
  localparam int Stats = 0;
`endif

  logic       clk;
  logic       reset_L;
  logic       init;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       Pausa_MF;
  logic       push;
  logic [5:0] data_out;
  logic [1:0] state_out;
  logic [7:0] cnt_vc0;
  logic [7:0] cnt_vc1;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pushes_seen = 0;
  int accepted = 0;
  logic [5:0] sb [$];

  pcie_src_ctrl #(.DEPTH(4), .PTR_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .init      (init),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .Pausa_MF  (Pausa_MF),
    .push      (push),
    .data_out  (data_out),
    .state_out (state_out),
    .cnt_vc0   (cnt_vc0),
    .cnt_vc1   (cnt_vc1),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every push must match the oldest accepted word.
  always @(negedge clk) begin
    if (push === 1'b1) begin
      logic [5:0] exp_w;
      pushes_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: push with data %h, expected no push", data_out);
      end else begin
        exp_w = sb.pop_front();
        if (data_out !== exp_w) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", data_out, exp_w);
        end
      end
    end
  end

  // One clock: apply inputs, log handshake before the edge, return #1 after it.
  task automatic step(input logic v, input logic [5:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    Pausa_MF = p;
    @(negedge clk);
    if (v && in_ready === 1'b1) begin
      sb.push_back(d);
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_L = 1'b0; init = 1'b1; in_valid = 1'b0; in_data = '0; Pausa_MF = 1'b0;
    #2;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL rst_push: got %b expected 0", push); end
    checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data_out); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
    @(posedge clk); #3;
    reset_L = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 6'h00, 1'b0);
      checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL init_state: got %0d expected 0", state_out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL init_ready: got %b expected 0", in_ready); end
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL init_push: got %b expected 0", push); end
    end
    init = 1'b0;
    step(1'b0, 6'h00, 1'b0);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL idle_state: got %0d expected 1", state_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", in_ready); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL idle_push: got %b expected 0", push); end
  endtask

  task automatic test_single;
    step(1'b1, 6'h21, 1'b0);
    checks++; if (push !== 1'b0 || state_out !== 2'd2) begin errors++; $display("FAIL single_e1: got push %b state %0d expected 0/2", push, state_out); end
    step(1'b0, 6'h00, 1'b0);
    checks++; if (push !== 1'b1 || data_out !== 6'h21) begin errors++; $display("FAIL single_e2: got push %b data %h expected 1/21", push, data_out); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL single_state: got %0d expected 1", state_out); end
    checks++; if (cnt_vc1 !== 8'(Stats)) begin errors++; $display("FAIL single_cnt1: got %0d expected %0d", cnt_vc1, Stats); end
    checks++; if (cnt_vc0 !== 8'd0) begin errors++; $display("FAIL single_cnt0: got %0d expected 0", cnt_vc0); end
    step(1'b0, 6'h00, 1'b0);
    checks++; if (push !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got push %b busy %b expected 0/0", push, busy); end
  endtask

  task automatic test_pause_full;
    logic [5:0] w;
    for (int i = 1; i <= 4; i++) begin
      w = 6'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_pre%0d: got %b expected 1", i, in_ready); end
      step(1'b1, w, 1'b1);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready); end
    checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL full_state: got %0d expected 3", state_out); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL full_push: got %b expected 0", push); end
    step(1'b1, 6'h3F, 1'b1);
    checks++; if (push !== 1'b0 || state_out !== 2'd3) begin errors++; $display("FAIL full_hold: got push %b state %0d expected 0/3", push, state_out); end
    step(1'b0, 6'h00, 1'b0);
    checks++; if (push !== 1'b0 || state_out !== 2'd2) begin errors++; $display("FAIL full_resume: got push %b state %0d expected 0/2", push, state_out); end
    for (int i = 1; i <= 4; i++) begin
      w = 6'(i);
      step(1'b0, 6'h00, 1'b0);
      checks++; if (push !== 1'b1 || data_out !== w) begin errors++; $display("FAIL full_drain%0d: got push %b data %h expected 1/%h", i, push, data_out, w); end
    end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL full_idle: got %0d expected 1", state_out); end
    checks++; if (cnt_vc0 !== 8'(4 * Stats) || cnt_vc1 !== 8'(Stats)) begin errors++; $display("FAIL full_cnt: got %0d/%0d expected %0d/%0d", cnt_vc0, cnt_vc1, 4 * Stats, Stats); end
    step(1'b0, 6'h00, 1'b0);
    checks++; if (push !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_done: got push %b busy %b expected 0/0", push, busy); end
  endtask

  task automatic test_stream;
    int base_push;
    int base_acc;
    logic p;
    base_push = pushes_seen;
    base_acc  = accepted;
    for (int i = 0; i < 20; i++) begin
      p = (i >= 6 && i <= 8);
      step(1'b1, 6'(i * 5 + 7), p);
      if (p) begin
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL stream_pause%0d: got push %b expected 0", i, push); end
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12 && busy === 1'b1; k++) step(1'b0, 6'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_drain: got busy %b expected 0", busy); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_left: got %0d words pending expected 0", sb.size()); end
    checks++; if (pushes_seen - base_push != accepted - base_acc) begin errors++; $display("FAIL stream_count: got %0d pushes expected %0d", pushes_seen - base_push, accepted - base_acc); end
  endtask

  task automatic test_init_flush;
    step(1'b1, 6'h11, 1'b1);
    step(1'b1, 6'h32, 1'b1);
    step(1'b1, 6'h13, 1'b1);
    checks++; if (busy !== 1'b1 || state_out !== 2'd3) begin errors++; $display("FAIL flush_pre: got busy %b state %0d expected 1/3", busy, state_out); end
    init = 1'b1;
    step(1'b0, 6'h00, 1'b1);
    checks++; if (state_out !== 2'd0 || push !== 1'b0) begin errors++; $display("FAIL flush_init: got state %0d push %b expected 0/0", state_out, push); end
    checks++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin errors++; $display("FAIL flush_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
    sb.delete();
    init = 1'b0;
    step(1'b0, 6'h00, 1'b0);
    checks++; if (state_out !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got state %0d busy %b expected 1/0", state_out, busy); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'h00, 1'b0);
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL flush_stale%0d: got push %b expected 0", i, push); end
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 6'h2A, 1'b0);
    step(1'b1, 6'h05, 1'b0);
    in_valid = 1'b0;
    checks++; if (push !== 1'b1 || data_out !== 6'h2A) begin errors++; $display("FAIL arst_pre: got push %b data %h expected 1/2a", push, data_out); end
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (push !== 1'b0 || data_out !== 6'h00) begin errors++; $display("FAIL arst_out: got push %b data %h expected 0/00", push, data_out); end
    checks++; if (state_out !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL arst_state: got state %0d busy %b expected 0/0", state_out, busy); end
    sb.delete();
    @(posedge clk); #1;
    reset_L = 1'b1;
    step(1'b0, 6'h00, 1'b0);
    checks++; if (state_out !== 2'd1 || push !== 1'b0) begin errors++; $display("FAIL arst_recover: got state %0d push %b expected 1/0", state_out, push); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pause_full();
    test_stream();
    test_init_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
